// File: rtl/hash_round_ctrl.sv
// Round sequencer for iterative hash cores: accepts message blocks, steps the round index
// for one of two round counts, and chains blocks into a held digest-valid handshake.
module hash_round_ctrl #(
    parameter int ROUNDS_A = 80,
    parameter int ROUNDS_B = 64,
    parameter int T_W      = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           abort,
    input  logic           blk_valid,
    input  logic           blk_first,
    input  logic           blk_last,
    input  logic           mode,
    output logic           blk_ready,
    output logic           iv_load,
    output logic           blk_load,
    output logic [T_W-1:0] t,
    output logic           round_en,
    output logic           round_last,
    output logic           upd_en,
    output logic           digest_valid,
    input  logic           digest_ready,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROUND  = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic [T_W-1:0] LAST_A = T_W'(ROUNDS_A - 1);
    localparam logic [T_W-1:0] LAST_B = T_W'(ROUNDS_B - 1);

    state_e         state_q, state_d;
    logic [T_W-1:0] t_q, t_d;
    logic           mode_q, mode_d;
    logic           last_q, last_d;
    logic           msg_start_q, msg_start_d;
    logic           accept_s;
    logic           round_en_q, round_last_q, upd_en_q, digest_valid_q, busy_q;

    function automatic logic [T_W-1:0] last_round(input logic m);
        return m ? LAST_B : LAST_A;
    endfunction

    // Handshake and load strobes: the only paths from inputs to outputs.
    always_comb begin
        blk_ready = (state_q == S_IDLE) & ~abort;
        accept_s  = blk_ready & blk_valid;
        blk_load  = accept_s;
        iv_load   = accept_s & (blk_first | msg_start_q);
    end

    // Next-state logic; abort overrides every state.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        mode_d      = mode_q;
        last_d      = last_q;
        msg_start_d = msg_start_q;
        if (abort) begin
            state_d     = S_IDLE;
            t_d         = {T_W{1'b0}};
            msg_start_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        state_d     = S_ROUND;
                        t_d         = {T_W{1'b0}};
                        mode_d      = mode;
                        last_d      = blk_last;
                        msg_start_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ROUND: begin
                    if (t_q == last_round(mode_q)) begin
                        state_d = S_UPDATE;
                        t_d     = {T_W{1'b0}};
                    end else begin
                        t_d = t_q + T_W'(1);
                    end
                end
                S_UPDATE: begin
                    if (last_q) begin
                        state_d     = S_DONE;
                        msg_start_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DONE: begin
                    if (digest_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    t_d     = {T_W{1'b0}};
                end
            endcase
        end
    end

    // State registers plus registered decode of the per-state strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            t_q            <= {T_W{1'b0}};
            mode_q         <= 1'b0;
            last_q         <= 1'b0;
            msg_start_q    <= 1'b1;
            round_en_q     <= 1'b0;
            round_last_q   <= 1'b0;
            upd_en_q       <= 1'b0;
            digest_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            t_q            <= t_d;
            mode_q         <= mode_d;
            last_q         <= last_d;
            msg_start_q    <= msg_start_d;
            round_en_q     <= (state_d == S_ROUND);
            round_last_q   <= (state_d == S_ROUND) && (t_d == last_round(mode_d));
            upd_en_q       <= (state_d == S_UPDATE);
            digest_valid_q <= (state_d == S_DONE);
            busy_q         <= (state_d != S_IDLE);
        end
    end

    assign t            = t_q;
    assign round_en     = round_en_q;
    assign round_last   = round_last_q;
    assign upd_en       = upd_en_q;
    assign digest_valid = digest_valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_hash_round_ctrl.sv
// Self-checking bench for hash_round_ctrl: scenario tasks plus randomized traffic checked
// against a latency model counting cycles since each block was accepted.
module tb_hash_round_ctrl;

    localparam int RA = 80;
    localparam int RB = 64;
    localparam int TW = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0, blk_valid = 1'b0, blk_first = 1'b0, blk_last = 1'b0, mode = 1'b0;
    logic digest_ready = 1'b0;
    logic blk_ready, iv_load, blk_load, round_en, round_last, upd_en, digest_valid, busy;
    logic [TW-1:0] t;

    int checks = 0;
    int fails  = 0;

    // Model: m_k = cycles since accept (0 = no block in flight), m_done = digest pending.
    int m_k, m_R;
    bit m_last, m_done, m_msg_start, m_acc;
    logic [TW+7:0] exp_vec;
    wire  [TW+7:0] obs = {blk_ready, iv_load, blk_load, round_en, round_last, upd_en,
                          digest_valid, busy, t};

    hash_round_ctrl #(.ROUNDS_A(RA), .ROUNDS_B(RB), .T_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .blk_valid(blk_valid),
        .blk_first(blk_first), .blk_last(blk_last), .mode(mode), .blk_ready(blk_ready),
        .iv_load(iv_load), .blk_load(blk_load), .t(t), .round_en(round_en),
        .round_last(round_last), .upd_en(upd_en), .digest_valid(digest_valid),
        .digest_ready(digest_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_k = 0; m_R = RA; m_last = 1'b0; m_done = 1'b0; m_msg_start = 1'b1; m_acc = 1'b0;
    endtask

    // Wait to mid-cycle and compute the expected outputs for the current inputs.
    task automatic sample();
        bit idle, rdy, ren;
        @(negedge clk);
        idle  = (m_k == 0) && !m_done;
        rdy   = idle && !abort;
        m_acc = rdy && blk_valid;
        ren   = (m_k >= 1) && (m_k <= m_R);
        exp_vec = {rdy, m_acc && (blk_first || m_msg_start), m_acc, ren,
                   (m_k > 0) && (m_k == m_R), (m_k > 0) && (m_k == m_R + 1),
                   m_done, (m_k != 0) || m_done, ren ? TW'(m_k - 1) : TW'(0)};
    endtask

    task automatic advance();
        @(posedge clk);
        if (abort) begin
            m_k = 0; m_done = 1'b0; m_msg_start = 1'b1;
        end else if (m_acc) begin
            m_k = 1; m_R = mode ? RB : RA; m_last = blk_last; m_msg_start = 1'b0;
        end else if (m_k > 0 && m_k == m_R + 1) begin
            m_k = 0;
            if (m_last) begin
                m_done = 1'b1; m_msg_start = 1'b1;
            end
        end else if (m_k > 0) begin
            m_k = m_k + 1;
        end else if (m_done && digest_ready) begin
            m_done = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 7'b0, {TW{1'b0}}}) begin
            fails++; $display("FAIL reset_values got=%h exp=%h", obs, {1'b1, 7'b0, {TW{1'b0}}});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            sample();
            checks++;
            if (obs !== exp_vec) begin
                fails++; $display("FAIL reset_idle k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_single(input bit m, input int hold);
        int r, upd_at, dv_at;
        r = m ? RB : RA; upd_at = -1; dv_at = -1;
        for (int k = 0; k < r + 4 + hold; k++) begin
            blk_valid    = (k == 0) || (k >= r + 2 && k < r + 2 + hold);
            blk_first    = (k == 0) ? 1'b1 : 1'($urandom);
            blk_last     = (k == 0) ? 1'b1 : 1'($urandom);
            mode         = (k == 0) ? m : 1'($urandom);
            digest_ready = (k >= r + 2 + hold);
            sample();
            checks++;
            if (obs !== exp_vec) begin
                fails++; $display("FAIL single_m%0d k=%0d got=%h exp=%h", m, k, obs, exp_vec);
            end
            if (upd_en === 1'b1 && upd_at < 0) upd_at = k;
            if (digest_valid === 1'b1 && dv_at < 0) dv_at = k;
            advance();
        end
        blk_valid = 1'b0;
        checks++;
        if (upd_at != r + 1) begin
            fails++; $display("FAIL single_upd_cycle got=%0d exp=%0d", upd_at, r + 1);
        end
        checks++;
        if (dv_at != r + 2) begin
            fails++; $display("FAIL single_dv_cycle got=%0d exp=%0d", dv_at, r + 2);
        end
    endtask

    task automatic test_multi();
        bit msel[3];
        int acc_at[3];
        int nacc, niv, dv_at, exp_acc, exp_dv;
        nacc = 0; niv = 0; dv_at = -1;
        foreach (msel[i]) begin msel[i] = 1'($urandom); acc_at[i] = -1; end
        digest_ready = 1'b1;
        for (int k = 0; k < 3 * (RA + 2) + 5; k++) begin
            blk_valid = (nacc < 3);
            blk_first = (nacc == 0);
            blk_last  = (nacc == 2);
            mode      = (nacc < 3) ? msel[nacc] : 1'b0;
            sample();
            checks++;
            if (obs !== exp_vec) begin
                fails++; $display("FAIL multi k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            if (iv_load === 1'b1) niv++;
            if (digest_valid === 1'b1 && dv_at < 0) dv_at = k;
            if (blk_load === 1'b1 && nacc < 3) begin acc_at[nacc] = k; nacc++; end
            advance();
        end
        blk_valid = 1'b0;
        exp_acc = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_at[i] != exp_acc) begin
                fails++; $display("FAIL multi_accept%0d got=%0d exp=%0d", i, acc_at[i], exp_acc);
            end
            exp_acc += (msel[i] ? RB : RA) + 2;
        end
        exp_dv = exp_acc;
        checks++;
        if (dv_at != exp_dv) begin
            fails++; $display("FAIL multi_dv_cycle got=%0d exp=%0d", dv_at, exp_dv);
        end
        checks++;
        if (niv != 1) begin
            fails++; $display("FAIL multi_iv_count got=%0d exp=1", niv);
        end
    endtask

    task automatic test_abort();
        int nupd;
        nupd = 0;
        digest_ready = 1'b1;
        for (int k = 0; k < 45; k++) begin
            blk_valid = (k == 0); blk_first = 1'b1; blk_last = 1'b1; mode = 1'b0;
            abort     = (k == 31);
            sample();
            checks++;
            if (obs !== exp_vec) begin
                fails++; $display("FAIL abort_round k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            if (upd_en === 1'b1) nupd++;
            advance();
        end
        abort = 1'b0;
        checks++;
        if (nupd != 0) begin
            fails++; $display("FAIL abort_no_upd got=%0d exp=0", nupd);
        end
        for (int k = 0; k < RB + 4; k++) begin
            blk_valid = (k == 0); blk_first = 1'b0; blk_last = 1'b1; mode = 1'b1;
            sample();
            checks++;
            if (obs !== exp_vec) begin
                fails++; $display("FAIL abort_next k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            if (k == 0) begin
                checks++;
                if (iv_load !== 1'b1) begin
                    fails++; $display("FAIL abort_iv_load got=%b exp=1", iv_load);
                end
            end
            advance();
        end
        blk_valid = 1'b0;
    endtask

    task automatic test_abort_accept();
        digest_ready = 1'b1;
        for (int k = 0; k < RA + 5; k++) begin
            abort = (k == 0); blk_valid = (k < 2); blk_first = 1'b1; blk_last = 1'b1;
            mode  = 1'b0;
            sample();
            checks++;
            if (obs !== exp_vec) begin
                fails++; $display("FAIL abort_accept k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            if (k < 2) begin
                checks++;
                if (blk_load !== (k == 1)) begin
                    fails++; $display("FAIL abort_accept_load k=%0d got=%b exp=%b", k, blk_load, k == 1);
                end
            end
            advance();
        end
        abort = 1'b0; blk_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int stop;
        stop = $urandom_range(5, 75);
        for (int k = 0; k < stop; k++) begin
            blk_valid = (k == 0); blk_first = 1'b0; blk_last = 1'b1; mode = 1'b0;
            sample();
            advance();
        end
        blk_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b1, 7'b0, {TW{1'b0}}}) begin
            fails++; $display("FAIL reset_mid got=%h exp=%h", obs, {1'b1, 7'b0, {TW{1'b0}}});
        end
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sample();
            checks++;
            if (obs !== exp_vec) begin
                fails++; $display("FAIL reset_mid_after k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            blk_valid    = ($urandom_range(0, 3) != 0);
            blk_first    = 1'($urandom);
            blk_last     = 1'($urandom);
            mode         = 1'($urandom);
            digest_ready = ($urandom_range(0, 2) == 0);
            abort        = ($urandom_range(0, 199) == 0);
            sample();
            checks++;
            if (obs !== exp_vec) begin
                fails++; $display("FAIL random k=%0d got=%h exp=%h", k, obs, exp_vec);
            end
            advance();
        end
        abort = 1'b0; blk_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single(1'b0, 0);
        test_single(1'b1, 5);
        test_multi();
        test_abort();
        test_abort_accept();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
